scaler_phase_gen: RTL and testbench

SCALER_PHASE_GEN -- requirements
Module: scaler_phase_gen

---
 rtl/scaler_phase_gen.sv | 219 +++++++++++++++++++++
 tb/tb_scaler_phase_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/scaler_phase_gen.sv
// ---------------------------------------------------------------------------
// scaler_phase_gen
//
// Purpose: phase/coefficient generator for a 1-D image scaler. For every
// output pixel of a line it produces the integer source position, the number
// of source pixels advanced since the previous output pixel, and a pair of
// interpolation weights (linear or nearest-neighbour). Beats are offered on a
// valid/ready handshake, one per cycle while the consumer is ready.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle pulse that begins a line (ignored while running)
//   mode_nn     in   1 = nearest-neighbour, 0 = linear (sampled at start)
//   scale_step  in   phase increment per output pixel (sampled at start)
//   phase_init  in   initial fractional phase (sampled at start)
//   out_count   in   output pixels per line (sampled at start)
//   m_ready     in   downstream accept
//   m_valid     out  beat valid
//   coe0        out  weight of source pixel src_idx
//   coe1        out  weight of source pixel src_idx+1
//   src_idx     out  integer source position
//   src_adv     out  source pixels advanced since the previous beat
//   last        out  final beat of the line
//   busy        out  line in progress
//   done        out  one-cycle pulse after the last beat is accepted
// ---------------------------------------------------------------------------
module scaler_phase_gen #(
  parameter int STEP        = 4096,
  parameter int COE_WIDTH   = 10,
  parameter int SCALE_WIDTH = 16,
  parameter int CNT_WIDTH   = 12,
  localparam int FW         = $clog2(STEP)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode_nn,
  input  logic [SCALE_WIDTH-1:0] scale_step,
  input  logic [FW-1:0]          phase_init,
  input  logic [CNT_WIDTH-1:0]   out_count,
  input  logic                   m_ready,
  output logic                   m_valid,
  output logic [COE_WIDTH-1:0]   coe0,
  output logic [COE_WIDTH-1:0]   coe1,
  output logic [CNT_WIDTH-1:0]   src_idx,
  output logic [CNT_WIDTH-1:0]   src_adv,
  output logic                   last,
  output logic                   busy,
  output logic                   done
);

  // Phase accumulator width: integer source position above FW fraction bits.
  localparam int PW    = CNT_WIDTH + FW;
  // Right shift that maps an FW-bit fraction onto the COE_WIDTH-1 bit weight.
  localparam int SHIFT = FW - COE_WIDTH + 1;
  localparam logic [COE_WIDTH-1:0] ONE = {1'b1, {(COE_WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [SCALE_WIDTH-1:0] step_q, step_d;
  logic                   mode_q, mode_d;
  logic [CNT_WIDTH-1:0]   rem_q, rem_d;      // beats still to come after the current one
  logic                   m_valid_q, m_valid_d;
  logic [COE_WIDTH-1:0]   coe0_q, coe0_d;
  logic [COE_WIDTH-1:0]   coe1_q, coe1_d;
  logic [CNT_WIDTH-1:0]   src_idx_q, src_idx_d;
  logic [CNT_WIDTH-1:0]   src_adv_q, src_adv_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Beat-generation datapath, shared by the first beat (loaded from the start
  // inputs) and every following beat (accumulator plus registered step).
  logic                   start_ok;
  logic                   accept;
  logic [PW-1:0]          load_phase;
  logic                   nn_sel;
  logic [CNT_WIDTH-1:0]   idx_new;
  logic [FW-1:0]          frac_new;
  logic [COE_WIDTH-1:0]   coe1_new;
  logic [CNT_WIDTH-1:0]   adv_new;

  // Weight applied to the right-hand source pixel for fraction f.
  function automatic logic [COE_WIDTH-1:0] coe1_of(input logic [FW-1:0] f,
                                                   input logic          nn);
    logic [COE_WIDTH+FW-1:0] ext;
    ext = {{COE_WIDTH{1'b0}}, f} >> SHIFT;
    if (nn) begin
      // STEP is a power of two, so f >= STEP/2 is exactly the fraction MSB.
      return f[FW-1] ? ONE : '0;
    end
    return ext[COE_WIDTH-1:0];
  endfunction

  always_comb begin
    start_ok   = start && (state_q == IDLE);
    accept     = m_valid_q && m_ready;
    load_phase = start_ok ? {{CNT_WIDTH{1'b0}}, phase_init}
                          : phase_q + PW'(step_q);
    nn_sel     = start_ok ? mode_nn : mode_q;
    idx_new    = load_phase[PW-1:FW];
    frac_new   = load_phase[FW-1:0];
    coe1_new   = coe1_of(frac_new, nn_sel);
    // The first beat reports its absolute position; later beats the delta,
    // which wraps naturally in CNT_WIDTH bits.
    adv_new    = start_ok ? idx_new : idx_new - src_idx_q;
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    step_d    = step_q;
    mode_d    = mode_q;
    rem_d     = rem_q;
    m_valid_d = m_valid_q;
    coe0_d    = coe0_q;
    coe1_d    = coe1_q;
    src_idx_d = src_idx_q;
    src_adv_d = src_adv_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          step_d  = scale_step;
          mode_d  = mode_nn;
          phase_d = load_phase;
          if (out_count != '0) begin
            state_d   = RUN;
            m_valid_d = 1'b1;
            busy_d    = 1'b1;
            src_idx_d = idx_new;
            src_adv_d = adv_new;
            coe1_d    = coe1_new;
            coe0_d    = ONE - coe1_new;
            rem_d     = out_count - CNT_WIDTH'(1);
            last_d    = (out_count == CNT_WIDTH'(1));
          end else begin
            // Empty line: nothing to emit, just report completion.
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (accept) begin
          if (last_q) begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
            last_d    = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            phase_d   = load_phase;
            src_idx_d = idx_new;
            src_adv_d = adv_new;
            coe1_d    = coe1_new;
            coe0_d    = ONE - coe1_new;
            rem_d     = rem_q - CNT_WIDTH'(1);
            last_d    = (rem_q == CNT_WIDTH'(1));
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      step_q    <= '0;
      mode_q    <= 1'b0;
      rem_q     <= '0;
      m_valid_q <= 1'b0;
      coe0_q    <= '0;
      coe1_q    <= '0;
      src_idx_q <= '0;
      src_adv_q <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      rem_q     <= rem_d;
      m_valid_q <= m_valid_d;
      coe0_q    <= coe0_d;
      coe1_q    <= coe1_d;
      src_idx_q <= src_idx_d;
      src_adv_q <= src_adv_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign m_valid = m_valid_q;
  assign coe0    = coe0_q;
  assign coe1    = coe1_q;
  assign src_idx = src_idx_q;
  assign src_adv = src_adv_q;
  assign last    = last_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_scaler_phase_gen.sv
module tb_scaler_phase_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode_nn;
  logic [15:0] scale_step;
  logic [11:0] phase_init;
  logic [11:0] out_count;
  logic        m_ready;
  logic        m_valid;
  logic [9:0]  coe0;
  logic [9:0]  coe1;
  logic [11:0] src_idx;
  logic [11:0] src_adv;
  logic        last;
  logic        busy;
  logic        done;

  scaler_phase_gen #(
    .STEP(4096), .COE_WIDTH(10), .SCALE_WIDTH(16), .CNT_WIDTH(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_nn(mode_nn),
    .scale_step(scale_step), .phase_init(phase_init), .out_count(out_count),
    .m_ready(m_ready), .m_valid(m_valid), .coe0(coe0), .coe1(coe1),
    .src_idx(src_idx), .src_adv(src_adv), .last(last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int adv;
    int c0;
    int c1;
    int lst;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input int adv, input int c0, input int c1, input int lst);
    beat_t b;
    b.idx = idx; b.adv = adv; b.c0 = c0; b.c1 = c1; b.lst = lst;
    exp_q.push_back(b);
  endtask

  // Monitor: outputs are stable at the falling edge; a beat is taken when
  // valid and ready are both high there.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: src_idx %0d with empty scoreboard at %0t", src_idx, $time);
        end else begin
          e = exp_q.pop_front();
          check("src_idx", int'(src_idx), e.idx);
          check("src_adv", int'(src_adv), e.adv);
          check("coe0", int'(coe0), e.c0);
          check("coe1", int'(coe1), e.c1);
          check("last", int'(last), e.lst);
          $display("beat idx=%0d adv=%0d coe0=%0d coe1=%0d last=%0d", src_idx, src_adv, coe0, coe1, last);
        end
      end
    end
  end

  // Called one step after a rising edge; returns one step after the edge
  // that sampled start, i.e. in cycle T+1.
  task automatic start_line(input logic nn, input int step, input int init, input int cnt);
    mode_nn    = nn;
    scale_step = 16'(step);
    phase_init = 12'(init);
    out_count  = 12'(cnt);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("first_valid_T+1", int'(m_valid), (cnt != 0) ? 1 : 0);
    check("busy_T+1", int'(busy), (cnt != 0) ? 1 : 0);
  endtask

  // Waits for done, counting rising edges from now; bounded.
  task automatic wait_done(input int exp_lat);
    int lat;
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", lat);
    end else begin
      check("done_latency", lat, exp_lat);
      check("busy_at_done", int'(busy), 0);
      check("valid_at_done", int'(m_valid), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode_nn = 1'b0; scale_step = '0;
    phase_init = '0; out_count = '0; m_ready = 1'b1;
    #2;
    check("rst_valid", int'(m_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_coe0", int'(coe0), 0);
    check("rst_src_idx", int'(src_idx), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Linear 2x upscale.
    push(0, 0, 512, 0, 0); push(0, 0, 256, 256, 0);
    push(1, 1, 512, 0, 0); push(1, 0, 256, 256, 1);
    start_line(1'b0, 2048, 0, 4);
    wait_done(4);

    // Non-integer downscale, started in the done cycle.
    push(0, 0, 512, 0, 0); push(1, 1, 256, 256, 0); push(3, 2, 512, 0, 1);
    start_line(1'b0, 6144, 0, 3);
    wait_done(3);

    // Backpressure on beat 2: phase 1024, 3072, 5120.
    push(0, 0, 384, 128, 0); push(0, 0, 128, 384, 0); push(1, 1, 384, 128, 1);
    start_line(1'b0, 2048, 1024, 3);
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_valid", int'(m_valid), 1);
      check("stall_src_idx", int'(src_idx), 0);
      check("stall_coe1", int'(coe1), 384);
      check("stall_last", int'(last), 0);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("beat3_valid", int'(m_valid), 1);
    check("beat3_src_idx", int'(src_idx), 1);
    wait_done(1);

    // Nearest neighbour.
    push(0, 0, 512, 0, 0); push(0, 0, 512, 0, 0);
    push(0, 0, 0, 512, 0); push(0, 0, 0, 512, 1);
    start_line(1'b1, 1024, 0, 4);
    wait_done(4);

    // Nearest-neighbour threshold: f = 2047 then 2048.
    push(0, 0, 512, 0, 0); push(0, 0, 0, 512, 1);
    start_line(1'b1, 1, 2047, 2);
    wait_done(2);

    // Empty line.
    start_line(1'b0, 2048, 0, 0);
    wait_done(0);
    @(posedge clk); #1;
    check("empty_no_valid", int'(m_valid), 0);

    // Zero step: every beat at the same position.
    push(0, 0, 137, 375, 0); push(0, 0, 137, 375, 0); push(0, 0, 137, 375, 1);
    start_line(1'b0, 0, 3000, 3);
    wait_done(3);

    // Reset mid-line.
    push(0, 0, 512, 0, 0); push(0, 0, 256, 256, 0); push(1, 1, 512, 0, 0);
    push(1, 0, 256, 256, 0); push(2, 1, 512, 0, 1);
    start_line(1'b0, 2048, 0, 5);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(m_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_src_idx", int'(src_idx), 0);
    check("arst_coe0", int'(coe0), 0);
    check("arst_coe1", int'(coe1), 0);
    check("arst_src_adv", int'(src_adv), 0);
    check("arst_last", int'(last), 0);
    check("pending_beats", exp_q.size(), 4);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_done_after_rst", int'(done), 0);
    end
    push(0, 0, 448, 64, 0); push(1, 1, 448, 64, 1);
    start_line(1'b0, 4096, 512, 2);
    wait_done(2);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
